// File: rtl/apb_sram_slave.sv
// APB4 completer in front of a word-organised SRAM. Handles byte-strobe merging, range,
// alignment and privilege checks, and programmable wait states with registered outputs.
module apb_sram_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          PRIV_ONLY   = 1'b0,
    parameter string       INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         s_apb_paddr,
    input  logic                s_apb_psel,
    input  logic                s_apb_penable,
    input  logic                s_apb_pwrite,
    input  logic [2:0]          s_apb_pprot,
    input  logic [DATA_W/8-1:0] s_apb_pstrb,
    input  logic [DATA_W-1:0]   s_apb_pwdata,
    output logic [DATA_W-1:0]   s_apb_prdata,
    output logic                s_apb_pready,
    output logic                s_apb_pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [31:0] SPAN   = 32'(DEPTH * STRB_W);

    typedef enum logic [1:0] {StIdle, StAccess, StProtErr} state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q;
    logic [AW-1:0]     idx_q;
    logic              err_q;
    logic              write_q;
    logic [STRB_W-1:0] strb_q;
    logic [3:0]        cnt_q;

    logic [31:0]       offset;
    logic              setup_err;
    logic [AW-1:0]     setup_idx;
    logic              commit;
    logic [DATA_W-1:0] merged;
    logic              unused_prot;

    assign unused_prot = ^s_apb_pprot[2:1];

    // Offset is taken before the range test so a base near the top of the map cannot overflow.
    assign offset    = s_apb_paddr - BASE_ADDR;
    assign setup_idx = offset[OFF_W +: AW];
    assign setup_err = (s_apb_paddr < BASE_ADDR) || (offset >= SPAN)
                     || (|offset[OFF_W-1:0])
                     || (PRIV_ONLY && !s_apb_pprot[0])
                     || (!s_apb_pwrite && (|s_apb_pstrb));

    // Completing edge: ACCESS with the counter exhausted and the master still selecting us.
    assign commit = (state_q == StAccess) && s_apb_psel && (cnt_q == 4'd0)
                  && write_q && !err_q;

    always_comb begin
        merged = mem[idx_q];
        for (int i = 0; i < STRB_W; i++) begin
            if (strb_q[i]) merged[8*i +: 8] = s_apb_pwdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[idx_q] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            err_q         <= 1'b0;
            write_q       <= 1'b0;
            strb_q        <= '0;
            cnt_q         <= 4'd0;
            s_apb_prdata  <= '0;
            s_apb_pready  <= 1'b0;
            s_apb_pslverr <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    s_apb_pready  <= 1'b0;
                    s_apb_pslverr <= 1'b0;
                    if (s_apb_psel && s_apb_penable) begin
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= 1'b1;
                        state_q       <= StProtErr;
                    end else if (s_apb_psel) begin
                        idx_q         <= setup_idx;
                        err_q         <= setup_err;
                        write_q       <= s_apb_pwrite;
                        strb_q        <= s_apb_pstrb;
                        cnt_q         <= 4'(WAIT_STATES);
                        // pready is registered, so it must be raised one edge ahead.
                        s_apb_pready  <= (WAIT_STATES == 0);
                        s_apb_pslverr <= (WAIT_STATES == 0) && setup_err;
                        if (!s_apb_pwrite) s_apb_prdata <= setup_err ? '0 : mem[setup_idx];
                        state_q       <= StAccess;
                    end
                end
                StAccess: begin
                    if (!s_apb_psel) begin
                        s_apb_pready  <= 1'b0;
                        s_apb_pslverr <= 1'b0;
                        state_q       <= StIdle;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q         <= cnt_q - 4'd1;
                        s_apb_pready  <= (cnt_q == 4'd1);
                        s_apb_pslverr <= (cnt_q == 4'd1) && err_q;
                    end else begin
                        s_apb_pready  <= 1'b0;
                        s_apb_pslverr <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    s_apb_pready  <= 1'b0;
                    s_apb_pslverr <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Bench for apb_sram_slave: three configurations (defaults; based/wait/priv; 64-bit) driven by
// vector tables, hand sequences and random traffic checked against a byte-level memory model.
module tb_apb_sram_slave;

    logic        clk, rst_n;
    logic [31:0] paddr;
    logic        pwrite, penable;
    logic [2:0]  pprot;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic        psel0, psel1, psel2;
    logic [31:0] rdata0, rdata1;
    logic [63:0] rdata2;
    logic        ready0, ready1, ready2, err0, err1, err2;

    apb_sram_slave #(.DATA_W(32), .DEPTH(256)) u0 (
        .clk(clk), .rst_n(rst_n), .s_apb_paddr(paddr), .s_apb_psel(psel0),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pprot(pprot),
        .s_apb_pstrb(pstrb[3:0]), .s_apb_pwdata(pwdata[31:0]), .s_apb_prdata(rdata0),
        .s_apb_pready(ready0), .s_apb_pslverr(err0));

    apb_sram_slave #(.DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3),
                     .PRIV_ONLY(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .s_apb_paddr(paddr), .s_apb_psel(psel1),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pprot(pprot),
        .s_apb_pstrb(pstrb[3:0]), .s_apb_pwdata(pwdata[31:0]), .s_apb_prdata(rdata1),
        .s_apb_pready(ready1), .s_apb_pslverr(err1));

    apb_sram_slave #(.DATA_W(64), .DEPTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .s_apb_paddr(paddr), .s_apb_psel(psel2),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pprot(pprot),
        .s_apb_pstrb(pstrb), .s_apb_pwdata(pwdata), .s_apb_prdata(rdata2),
        .s_apb_pready(ready2), .s_apb_pslverr(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration of each instance, as seen by the reference model.
    localparam longint BASE [3] = '{64'h0, 64'h1000, 64'h0};
    localparam int     BW   [3] = '{4, 4, 8};
    localparam int     DEP  [3] = '{256, 256, 16};
    localparam int     WS   [3] = '{0, 3, 0};
    localparam bit     PRIV [3] = '{1'b0, 1'b1, 1'b0};

    logic [63:0] model [3][256];
    int passed = 0, total = 0;

    typedef struct {
        int          w;
        bit          wr;
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic [2:0]  p;
        logic [63:0] exp_rd;
        bit          exp_er;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? ready0 : (w == 1) ? ready1 : ready2;
    endfunction
    function automatic logic erf(input int w);
        return (w == 0) ? err0 : (w == 1) ? err1 : err2;
    endfunction
    function automatic logic [63:0] rdf(input int w);
        return (w == 0) ? {32'h0, rdata0} : (w == 1) ? {32'h0, rdata1} : rdata2;
    endfunction

    function automatic bit m_err(input int w, input bit wr, input logic [31:0] a,
                                 input logic [7:0] s, input logic [2:0] p);
        longint ua = longint'(a);
        return ua < BASE[w] || ua >= BASE[w] + DEP[w] * BW[w] || (ua % BW[w]) != 0
            || (PRIV[w] && !p[0]) || (!wr && s != 8'h0);
    endfunction

    function automatic int m_idx(input int w, input logic [31:0] a);
        return int'((longint'(a) - BASE[w]) / BW[w]);
    endfunction

    task automatic m_write(input int w, input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] s);
        int k = m_idx(w, a);
        for (int i = 0; i < BW[w]; i++)
            if (s[i]) model[w][k][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic xfer(input int w, input bit wr, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [2:0] p,
                        output logic [63:0] rd, output logic er, output int cyc);
        @(negedge clk);
        psel0 = (w == 0); psel1 = (w == 1); psel2 = (w == 2);
        paddr = a; pwrite = wr; pwdata = d; pstrb = s; pprot = p; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        cyc = 1;
        while (!rdy(w) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rd = rdf(w);
        er = erf(w);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel0 = 0; psel1 = 0; psel2 = 0; penable = 0; pwrite = 0; pstrb = 0;
    endtask

    // One transfer checked against the model; the model is updated on an OKAY write.
    task automatic do_op(input string name, input int w, input bit wr, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] s, input logic [2:0] p);
        logic [63:0] rd;
        logic        er;
        int          cyc;
        bit          ee = m_err(w, wr, a, s, p);
        xfer(w, wr, a, d, s, p, rd, er, cyc);
        check({name, "_len"}, 64'(cyc), 64'(WS[w] + 1));
        check({name, "_err"}, 64'(er), 64'(ee));
        if (!wr) check({name, "_rdata"}, rd, ee ? 64'h0 : model[w][m_idx(w, a)]);
        if (wr && !ee) m_write(w, a, d, s);
    endtask

    function automatic vec_t mk(input int w, input bit wr, input logic [31:0] a,
                                input logic [63:0] d, input logic [7:0] s, input logic [2:0] p,
                                input logic [63:0] exp_rd, input bit exp_er);
        vec_t v;
        v.w = w; v.wr = wr; v.a = a; v.d = d; v.s = s; v.p = p;
        v.exp_rd = exp_rd; v.exp_er = exp_er;
        return v;
    endfunction

    initial begin
        logic [63:0] rd;
        logic        er;
        int          cyc;

        tbl.push_back(mk(0, 1, 32'h10, 64'hDEADBEEF, 8'hF, 3'd0, 64'h0, 0));
        tbl.push_back(mk(0, 0, 32'h10, 64'h0, 8'h0, 3'd0, 64'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 32'h20, 64'h11223344, 8'hF, 3'd0, 64'h0, 0));
        tbl.push_back(mk(0, 1, 32'h20, 64'hAABBCCDD, 8'h5, 3'd0, 64'h0, 0));
        tbl.push_back(mk(0, 0, 32'h20, 64'h0, 8'h0, 3'd0, 64'h11BB33DD, 0));
        tbl.push_back(mk(0, 0, 32'h400, 64'h0, 8'h0, 3'd0, 64'h0, 1));
        tbl.push_back(mk(0, 1, 32'h12, 64'h0BAD0BAD, 8'hF, 3'd0, 64'h0, 1));
        tbl.push_back(mk(0, 0, 32'h10, 64'h0, 8'h0, 3'd0, 64'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 32'h14, 64'hCAFEF00D, 8'hF, 3'd0, 64'h0, 0));
        tbl.push_back(mk(0, 1, 32'h14, 64'hFFFFFFFF, 8'h0, 3'd0, 64'h0, 0));
        tbl.push_back(mk(0, 0, 32'h14, 64'h0, 8'h0, 3'd0, 64'hCAFEF00D, 0));
        tbl.push_back(mk(0, 0, 32'h10, 64'h0, 8'hF, 3'd0, 64'h0, 1));
        tbl.push_back(mk(1, 1, 32'h1010, 64'h12345678, 8'hF, 3'd1, 64'h0, 0));
        tbl.push_back(mk(1, 0, 32'h1010, 64'h0, 8'h0, 3'd1, 64'h12345678, 0));
        tbl.push_back(mk(1, 0, 32'h1010, 64'h0, 8'h0, 3'd0, 64'h0, 1));
        tbl.push_back(mk(1, 1, 32'h1010, 64'hFFFFFFFF, 8'hF, 3'd0, 64'h0, 1));
        tbl.push_back(mk(1, 0, 32'h1010, 64'h0, 8'h0, 3'd1, 64'h12345678, 0));
        tbl.push_back(mk(1, 0, 32'h0FFC, 64'h0, 8'h0, 3'd1, 64'h0, 1));
        tbl.push_back(mk(1, 0, 32'h1400, 64'h0, 8'h0, 3'd1, 64'h0, 1));
        tbl.push_back(mk(1, 1, 32'h13FC, 64'h55AA55AA, 8'hF, 3'd1, 64'h0, 0));
        tbl.push_back(mk(1, 0, 32'h13FC, 64'h0, 8'h0, 3'd1, 64'h55AA55AA, 0));
        tbl.push_back(mk(2, 1, 32'h78, 64'hFFEEDDCC_BBAA9988, 8'hFF, 3'd0, 64'h0, 0));
        tbl.push_back(mk(2, 1, 32'h78, 64'h01234567_89ABCDEF, 8'hF0, 3'd0, 64'h0, 0));
        tbl.push_back(mk(2, 0, 32'h78, 64'h0, 8'h0, 3'd0, 64'h01234567_BBAA9988, 0));
        tbl.push_back(mk(2, 0, 32'h80, 64'h0, 8'h0, 3'd0, 64'h0, 1));
        tbl.push_back(mk(2, 0, 32'h7C, 64'h0, 8'h0, 3'd0, 64'h0, 1));

        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 256; k++) model[w][k] = 64'h0;

        rst_n = 0; psel0 = 0; psel1 = 0; psel2 = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
        repeat (3) @(negedge clk);
        check("reset_ready", {61'h0, ready0, ready1, ready2}, 64'h0);
        check("reset_err", {61'h0, err0, err1, err2}, 64'h0);
        check("reset_rdata", rdata2 | {32'h0, rdata0 | rdata1}, 64'h0);
        rst_n = 1;

        // Give every word a known value so the model never has to guess.
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < DEP[w]; k++)
                do_op("init", w, 1, 32'(BASE[w] + longint'(k * BW[w])),
                      {$urandom, $urandom}, 8'hFF, 3'd1);

        foreach (tbl[i]) begin
            xfer(tbl[i].w, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p, rd, er, cyc);
            check($sformatf("vec%0d_len", i), 64'(cyc), 64'(WS[tbl[i].w] + 1));
            check($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].exp_er));
            if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            if (tbl[i].wr && !tbl[i].exp_er) m_write(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s);
        end

        // pready lasts exactly one cycle.
        do_op("ws3_wr", 1, 1, 32'h1020, 64'h0000_7777, 8'hF, 3'd1);
        bus_idle();
        check("ws3_ready_one_cycle", 64'(ready1), 64'h0);

        // Protocol violation: penable without SETUP.
        @(negedge clk);
        psel0 = 1; penable = 1; pwrite = 1; paddr = 32'h10; pwdata = 64'h0; pstrb = 8'hF;
        @(negedge clk);
        check("protviol_ready", 64'(ready0), 64'h1);
        check("protviol_err", 64'(err0), 64'h1);
        psel0 = 0; penable = 0;
        @(negedge clk);
        check("protviol_ready_drop", 64'(ready0), 64'h0);
        do_op("protviol_rb", 0, 0, 32'h10, 64'h0, 8'h0, 3'd0);

        // psel dropped mid-ACCESS abandons the write.
        @(negedge clk);
        psel1 = 1; penable = 0; pwrite = 1; paddr = 32'h1010; pwdata = 64'h0; pstrb = 8'hF;
        pprot = 3'd1;
        @(negedge clk);
        penable = 1;
        @(negedge clk);
        psel1 = 0; penable = 0;
        repeat (2) begin
            @(negedge clk);
            check("abandon_no_ready", 64'(ready1), 64'h0);
        end
        do_op("abandon_rb", 1, 0, 32'h1010, 64'h0, 8'h0, 3'd1);

        // Reset while a WAIT_STATES=3 write is in ACCESS.
        @(negedge clk);
        psel1 = 1; penable = 0; pwrite = 1; paddr = 32'h1010; pwdata = 64'hBAD0BAD0;
        pstrb = 8'hF; pprot = 3'd1;
        @(negedge clk);
        penable = 1;
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_mid_ready", 64'(ready1), 64'h0);
        check("rst_mid_err", 64'(err1), 64'h0);
        check("rst_mid_rdata", 64'(rdata1), 64'h0);
        @(negedge clk);
        psel1 = 0; penable = 0; pwrite = 0;
        rst_n = 1;
        do_op("rst_mid_rb", 1, 0, 32'h1010, 64'h0, 8'h0, 3'd1);

        // Random back-to-back traffic across all three instances.
        for (int n = 0; n < 300; n++) begin
            int          w = $urandom_range(0, 2);
            bit          wr = 1'($urandom_range(0, 1));
            int          r = $urandom_range(0, 15);
            logic [31:0] a = 32'(BASE[w] + longint'($urandom_range(0, DEP[w] - 1) * BW[w]));
            logic [7:0]  s = 8'($urandom) & 8'((1 << BW[w]) - 1);
            logic [2:0]  p = {2'b0, ($urandom_range(0, 7) != 0)};
            if (r == 0) a = a + 32'($urandom_range(1, BW[w] - 1));
            if (r == 1) a = 32'(BASE[w] + longint'(DEP[w] * BW[w]) + longint'(4 * r));
            if (r == 2 && BASE[w] != 0) a = 32'(BASE[w] - 4);
            if (!wr && r != 3) s = 8'h0;
            do_op("rand", w, wr, a, {$urandom, $urandom}, s, p);
        end
        bus_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
